// File: rtl/bridge_stream_master.sv
// Avalon-style bridge master: runs a counted burst of single-word reads into a stream FIFO
// or writes from a stream input. Optional ack timeout enabled by the BRIDGE_TIMEOUT_EN macro.
module bridge_stream_master #(
    parameter int ADDR_W      = 26,
    parameter int DATA_W      = 16,
    parameter int BE_W        = DATA_W / 8,
    parameter int LEN_W       = 16,
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] bridge_address,
    output logic [BE_W-1:0]   bridge_byte_enable,
    output logic              bridge_read,
    output logic              bridge_write,
    output logic [DATA_W-1:0] bridge_write_data,
    input  logic              bridge_acknowledge,
    input  logic [DATA_W-1:0] bridge_read_data
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    if ((DATA_W % 8) != 0 || FIFO_DEPTH < 2 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("bridge_stream_master: illegal parameter combination");
    end

    typedef enum logic [2:0] {IDLE, RD_REQ, WR_FETCH, WR_REQ, GAP, FIN} state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [LEN_W-1:0]    r_remaining;
    logic                r_is_write;
    logic                r_read;
    logic                r_write;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_wr_ready;
    logic                r_done;
    logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wptr;
    logic [PTR_W-1:0]    r_rptr;
    logic [CNT_W-1:0]    r_count;

    logic                w_push;
    logic                w_pop;
    logic [CNT_W-1:0]    w_count_next;
    logic                w_room;
    logic                w_timeout;

    assign w_push       = r_read & bridge_acknowledge;
    assign w_pop        = (r_count != '0) & rd_ready;
    assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    // Only one read is ever in flight, so room after this edge is enough to issue the next one.
    assign w_room       = (w_count_next < CNT_W'(FIFO_DEPTH));

`ifdef BRIDGE_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC) + 1;
    logic [TMO_W-1:0] r_tmo;
    logic             r_error;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_tmo   <= TMO_W'(TIMEOUT_CYC - 1);
            r_error <= 1'b0;
        end else begin
            if (!(r_read | r_write))
                r_tmo <= TMO_W'(TIMEOUT_CYC - 1);
            else if (r_tmo != '0)
                r_tmo <= r_tmo - TMO_W'(1);
            if (r_state == IDLE && cmd_valid)
                r_error <= 1'b0;
            else if (w_timeout)
                r_error <= 1'b1;
        end
    end

    assign w_timeout = (r_read | r_write) & ~bridge_acknowledge & (r_tmo == '0);
    assign error     = r_error;
`else
    assign w_timeout = 1'b0;
    assign error     = 1'b0;
`endif

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_is_write  <= 1'b0;
            r_read      <= 1'b0;
            r_write     <= 1'b0;
            r_wdata     <= '0;
            r_wr_ready  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (cmd_valid) begin
                    r_addr      <= cmd_addr;
                    r_remaining <= cmd_len;
                    r_is_write  <= cmd_write;
                    if (cmd_len == '0) begin
                        r_state <= FIN;
                    end else if (cmd_write) begin
                        r_state    <= WR_FETCH;
                        r_wr_ready <= 1'b1;
                    end else begin
                        r_state <= RD_REQ;
                        r_read  <= w_room;
                    end
                end
                RD_REQ: begin
                    if (r_read) begin
                        if (bridge_acknowledge) begin
                            r_read      <= 1'b0;
                            r_remaining <= r_remaining - LEN_W'(1);
                            r_state     <= GAP;
                        end else if (w_timeout) begin
                            r_read  <= 1'b0;
                            r_state <= FIN;
                        end
                    end else begin
                        r_read <= w_room;
                    end
                end
                WR_FETCH: if (wr_valid) begin
                    r_wdata    <= wr_data;
                    r_wr_ready <= 1'b0;
                    r_write    <= 1'b1;
                    r_state    <= WR_REQ;
                end
                WR_REQ: begin
                    if (bridge_acknowledge) begin
                        r_write     <= 1'b0;
                        r_remaining <= r_remaining - LEN_W'(1);
                        r_state     <= GAP;
                    end else if (w_timeout) begin
                        r_write <= 1'b0;
                        r_state <= FIN;
                    end
                end
                GAP: begin
                    r_addr <= r_addr + ADDR_W'(BE_W);
                    if (r_remaining == '0) begin
                        r_state <= FIN;
                    end else if (r_is_write) begin
                        r_state    <= WR_FETCH;
                        r_wr_ready <= 1'b1;
                    end else begin
                        r_state <= RD_REQ;
                        r_read  <= w_room;
                    end
                end
                FIN: begin
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= bridge_read_data;
                r_wptr        <= r_wptr + PTR_W'(1);
            end
            if (w_pop)
                r_rptr <= r_rptr + PTR_W'(1);
            r_count <= w_count_next;
        end
    end

    assign cmd_ready          = (r_state == IDLE);
    assign busy               = (r_state != IDLE);
    assign done               = r_done;
    assign wr_ready           = r_wr_ready;
    assign rd_valid           = (r_count != '0);
    assign rd_data            = r_mem[r_rptr];
    assign bridge_address     = r_addr;
    assign bridge_read        = r_read;
    assign bridge_write       = r_write;
    assign bridge_write_data  = r_wdata;
    assign bridge_byte_enable = {BE_W{r_read | r_write}};

endmodule

// File: tb/tb_bridge_stream_master.sv
// Directed bench for bridge_stream_master: bridge slave responder, stream source/sink, fixed expectations.
module tb_bridge_stream_master;

    localparam int ADDR_W = 26, DATA_W = 16, BE_W = 2, LEN_W = 16, FIFO_DEPTH = 8, TIMEOUT_CYC = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid, cmd_ready, cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic [DATA_W-1:0] wr_data;
    logic              wr_valid, wr_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid, rd_ready;
    logic              busy, done, error;
    logic [ADDR_W-1:0] bridge_address;
    logic [BE_W-1:0]   bridge_byte_enable;
    logic              bridge_read, bridge_write;
    logic [DATA_W-1:0] bridge_write_data;
    logic              bridge_acknowledge;
    logic [DATA_W-1:0] bridge_read_data;

    bridge_stream_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .LEN_W(LEN_W),
        .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk_clk(clk), .reset_reset(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .busy(busy), .done(done), .error(error),
        .bridge_address(bridge_address), .bridge_byte_enable(bridge_byte_enable),
        .bridge_read(bridge_read), .bridge_write(bridge_write),
        .bridge_write_data(bridge_write_data),
        .bridge_acknowledge(bridge_acknowledge), .bridge_read_data(bridge_read_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0;
    int n_acks = 0, req_cycles = 0, done_cnt = 0, overlap = 0;
    int ack_delay = 0, ack_wait = 0, rd_seq = 0, wr_seq = 0;
    logic ack_en = 1'b1, spur_ack = 1'b0, wr_hs = 1'b0;
    logic [31:0] addr_q[$], be_q[$], wdata_q[$], rd_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bridge slave: acks after ack_delay extra cycles of an active request.
    always @(negedge clk) begin
        if (rst) begin
            bridge_acknowledge = 1'b0;
            ack_wait = 0;
        end else if (spur_ack) begin
            bridge_acknowledge = 1'b1;
            bridge_read_data = 16'hDEAD;
            spur_ack = 1'b0;
        end else if (ack_en && (bridge_read || bridge_write)) begin
            if (ack_wait == ack_delay) begin
                bridge_acknowledge = 1'b1;
                ack_wait = 0;
                n_acks++;
                addr_q.push_back(32'(bridge_address));
                be_q.push_back(32'(bridge_byte_enable));
                if (bridge_read) begin
                    bridge_read_data = 16'hA000 + 16'(rd_seq);
                    rd_seq++;
                end else begin
                    wdata_q.push_back(32'(bridge_write_data));
                end
            end else begin
                bridge_acknowledge = 1'b0;
                ack_wait++;
            end
        end else begin
            bridge_acknowledge = 1'b0;
            ack_wait = 0;
        end
    end

    // Write stream source: advance data after each accepted word.
    always @(negedge clk) begin
        if (wr_hs) begin
            wr_seq++;
            wr_data = 16'h5000 + 16'(wr_seq);
        end
        wr_hs = wr_valid && wr_ready;
    end

    always @(negedge clk) begin
        #2;
        if (!rst) begin
            if (rd_valid && rd_ready) rd_q.push_back(32'(rd_data));
            if (done) done_cnt++;
            if (bridge_read && bridge_write) overlap++;
            if (bridge_read || bridge_write) req_cycles++;
        end
    end

    task automatic send_cmd(input logic wr, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] n);
        @(negedge clk);
        check("cmd_ready_before_cmd", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = n;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        logic seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        int d0, r0;
        rst = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
        wr_data = 16'h5000; wr_valid = 0; rd_ready = 0;
        bridge_acknowledge = 0; bridge_read_data = '0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_outputs", {busy, done, error, rd_valid, wr_ready, bridge_read, bridge_write}, 32'd0);
        check("rst_addr", 32'(bridge_address), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Read of 4 words with a slow slave.
        rd_ready = 1; ack_delay = 2; rd_seq = 0; d0 = done_cnt;
        send_cmd(1'b0, 26'h100, 16'd4);
        check("t1_first_req", 32'(bridge_read), 32'd1);
        check("t1_be", 32'(bridge_byte_enable), 32'h3);
        wait_done("t1_done", 100);
        check("t1_busy_after", 32'(busy), 32'd0);
        repeat (4) @(negedge clk);
        check("t1_done_count", 32'(done_cnt - d0), 32'd1);
        check("t1_nacks", 32'(addr_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t1_addr%0d", i), addr_q[i], 32'h100 + 32'(2 * i));
            check($sformatf("t1_rd%0d", i), rd_q[i], 32'hA000 + 32'(i));
        end
        check("t1_rdq_size", 32'(rd_q.size()), 32'd4);

        // Write of 2 words across the top of the address space.
        addr_q.delete(); be_q.delete(); ack_delay = 0;
        wr_valid = 1;
        send_cmd(1'b1, 26'h3FFFFFE, 16'd2);
        wait_done("t2_done", 100);
        check("t2_nacks", 32'(wdata_q.size()), 32'd2);
        check("t2_addr0", addr_q[0], 32'h3FFFFFE);
        check("t2_addr1_wrap", addr_q[1], 32'h0);
        check("t2_wd0", wdata_q[0], 32'h5000);
        check("t2_wd1", wdata_q[1], 32'h5001);
        check("t2_be0", be_q[0], 32'h3);
        check("t2_be1", be_q[1], 32'h3);

        // Read of 12 words with a stalled consumer: FIFO fills to 8 then reads stop.
        rd_q.delete(); addr_q.delete(); rd_seq = 0; ack_delay = 1; rd_ready = 0;
        check("t3_fifo_empty", 32'(rd_valid), 32'd0);
        r0 = n_acks;
        send_cmd(1'b0, 26'h200, 16'd12);
        repeat (60) @(negedge clk);
        check("t3_stall_acks", 32'(n_acks - r0), 32'd8);
        check("t3_read_held", 32'(bridge_read), 32'd0);
        check("t3_busy_stall", 32'(busy), 32'd1);
        spur_ack = 1'b1;
        repeat (3) @(negedge clk);
        check("t3_spur_ignored", 32'(n_acks - r0), 32'd8);
        rd_ready = 1;
        wait_done("t3_done", 300);
        repeat (12) @(negedge clk);
        check("t3_rdq_size", 32'(rd_q.size()), 32'd12);
        for (int i = 0; i < 12; i++)
            check($sformatf("t3_rd%0d", i), rd_q[i], 32'hA000 + 32'(i));
        check("t3_last_addr", addr_q[11], 32'h216);

        // Zero-length command: done two cycles after accept, no bus traffic.
        r0 = req_cycles; d0 = done_cnt;
        send_cmd(1'b0, 26'h300, 16'd0);
        check("t4_no_done_yet", 32'(done), 32'd0);
        check("t4_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("t4_done", 32'(done), 32'd1);
        check("t4_busy_low", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        check("t4_no_requests", 32'(req_cycles - r0), 32'd0);
        check("t4_done_count", 32'(done_cnt - d0), 32'd1);

        // Leave 2 words in the FIFO, then reset during a write request.
        rd_ready = 0; rd_seq = 0; ack_delay = 0;
        send_cmd(1'b0, 26'h400, 16'd2);
        wait_done("t5_rd_done", 50);
        check("t5_fifo_valid", 32'(rd_valid), 32'd1);
        check("t5_fifo_head", 32'(rd_data), 32'hA000);
        ack_en = 0;
        send_cmd(1'b1, 26'h500, 16'd3);
        repeat (3) @(negedge clk);
        check("t5_write_active", 32'(bridge_write), 32'd1);
        check("t5_error_idle", 32'(error), 32'd0);
        rst = 1'b1;
        #1;
        check("t5_write_dropped", 32'(bridge_write), 32'd0);
        check("t5_cmd_ready", 32'(cmd_ready), 32'd1);
        check("t5_error", 32'(error), 32'd0);
        check("t5_rd_valid", 32'(rd_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ack_en = 1;
        @(negedge clk);

`ifdef BRIDGE_TIMEOUT_EN
        // Slave never answers: request drops after 16 cycles and error is raised.
        ack_en = 0; rd_ready = 1; r0 = req_cycles; d0 = done_cnt;
        send_cmd(1'b0, 26'h40, 16'd3);
        wait_done("t6_done", 100);
        check("t6_error", 32'(error), 32'd1);
        check("t6_req_cycles", 32'(req_cycles - r0), 32'd16);
        repeat (2) @(negedge clk);
        check("t6_done_count", 32'(done_cnt - d0), 32'd1);
        check("t6_error_sticky", 32'(error), 32'd1);
        ack_en = 1;
        send_cmd(1'b0, 26'h40, 16'd0);
        check("t6_error_cleared", 32'(error), 32'd0);
        repeat (3) @(negedge clk);
`endif

        check("rw_exclusive", 32'(overlap), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
